// File: rtl/av2_recon_writeback_if.sv
// Recon-beat input and frame-buffer write port of the write-back stage.
// slave  : the write-back stage (consumes recon beats, drives memory writes)
// master : the decoder/memory side (drives recon beats, drives mem_wr_ready)
interface av2_recon_writeback_if #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned ADDR_W = 32
);
   logic [DATA_W-1:0] recon_data;
   logic [ADDR_W-1:0] recon_addr;
   logic              recon_wr_en;
   logic              mem_wr_valid;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_wr_ready;

   modport master (
      output recon_data, recon_addr, recon_wr_en, mem_wr_ready,
      input  mem_wr_valid, mem_wr_addr, mem_wr_data
   );

   modport slave (
      input  recon_data, recon_addr, recon_wr_en, mem_wr_ready,
      output mem_wr_valid, mem_wr_addr, mem_wr_data
   );
endinterface

// File: rtl/av2_recon_writeback.sv
// Reconstruction write-back: buffers decoder beats in a small FIFO, converts
// beat indices to byte addresses and drains them over a valid/ready port.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          recon beat input + memory write port (slave modport)
//   tile_done    decoder completion (level or pulse)
//   base_addr    frame-buffer byte base, stable while not IDLE
//   clear        sync clear of FSM, overflow and beat_count
//   fifo_level   FIFO occupancy
//   overflow     sticky dropped-beat flag
//   beat_count   completed memory handshakes (wraps)
//   wb_done      one-cycle completion pulse
module av2_recon_writeback #(
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   av2_recon_writeback_if.slave bus,
   input  logic                 tile_done,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic                 clear,
   output logic [LVL_W-1:0]     fifo_level,
   output logic                 overflow,
   output logic [15:0]          beat_count,
   output logic                 wb_done
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [LVL_W-1:0]   level_nxt;
   logic [ADDR_W-1:0]  push_addr;
   logic               valid_q;
   logic               pop, push_acc, drop;
   logic               enter_drain;
   logic               done_block;

   logic [ADDR_W-1:0]  addr_mem [FIFO_DEPTH];
   logic [DATA_W-1:0]  data_mem [FIFO_DEPTH];

   // Handshake and push acceptance; a same-cycle pop frees the full slot
   assign pop       = valid_q & bus.mem_wr_ready;
   assign push_acc  = bus.recon_wr_en & ((fifo_level < LVL_W'(FIFO_DEPTH)) | pop);
   assign drop      = bus.recon_wr_en & ~push_acc;
   assign push_addr = base_addr + (bus.recon_addr << 4);
   assign level_nxt = fifo_level + LVL_W'(push_acc) - LVL_W'(pop);

   // Head entry is masked while empty so outputs read zero out of reset
   assign bus.mem_wr_valid = valid_q;
   assign bus.mem_wr_addr  = valid_q ? addr_mem[rd_ptr] : '0;
   assign bus.mem_wr_data  = valid_q ? data_mem[rd_ptr] : '0;

   // FIFO storage (contents need no reset; pointers define validity)
   always_ff @(posedge clk) begin
      if (push_acc) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= bus.recon_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         valid_q    <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_level <= level_nxt;
         valid_q    <= (level_nxt != '0);
      end
   end

   // Next-state logic; clear overrides every transition
   always_comb begin
      state_nxt   = state;
      enter_drain = 1'b0;
      unique case (state)
         IDLE: begin
            if (tile_done && !done_block) state_nxt = DRAIN;
            else if (push_acc)            state_nxt = ACTIVE;
         end
         ACTIVE: begin
            if (tile_done && !done_block) state_nxt = DRAIN;
         end
         DRAIN: begin
            if ((fifo_level == '0) && !push_acc) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
      enter_drain = (state_nxt == DRAIN) && (state != DRAIN);
   end

   // State, status and completion registers.
   // done_block stops a still-high tile_done from re-arming DRAIN once the
   // FSM has cycled back to IDLE; it clears when tile_done falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wb_done    <= 1'b0;
         overflow   <= 1'b0;
         beat_count <= '0;
         done_block <= 1'b0;
      end else begin
         state   <= state_nxt;
         wb_done <= (state_nxt == DONE);
         if (!tile_done)       done_block <= 1'b0;
         else if (enter_drain) done_block <= 1'b1;
         if (clear) begin
            overflow   <= 1'b0;
            beat_count <= '0;
         end else begin
            if (drop) overflow   <= 1'b1;
            if (pop)  beat_count <= beat_count + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_av2_recon_writeback.sv
// Scoreboard bench for av2_recon_writeback: stimulus queues expected writes,
// a negedge monitor checks each memory handshake and counts wb_done pulses.
module tb_av2_recon_writeback;
   localparam int unsigned DATA_W = 128;
   localparam int unsigned ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              tile_done;
   logic              clear;
   logic [ADDR_W-1:0] base_addr;
   logic [3:0]        fifo_level;
   logic              overflow;
   logic [15:0]       beat_count;
   logic              wb_done;

   always #5 clk = ~clk;

   av2_recon_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   av2_recon_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .tile_done  (tile_done),
      .base_addr  (base_addr),
      .clear      (clear),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .beat_count (beat_count),
      .wb_done    (wb_done)
   );

   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   n_writes = 0;
   int   wb_pulses = 0;
   int   last_hs_edge = -1;
   int   last_wb_edge = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a handshake is visible at negedge and completes on the next posedge
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_wr_valid && bus.mem_wr_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr %0h expected no write", bus.mem_wr_addr);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 128'(bus.mem_wr_addr), 128'(e.addr));
               chk("wr_data", bus.mem_wr_data, e.data);
            end
            n_writes++;
            last_hs_edge = cyc + 1;
         end
         if (wb_done) begin
            wb_pulses++;
            last_wb_edge = cyc;
         end
      end
   end

   function automatic logic [127:0] pat(input int i);
      logic [7:0]  b;
      logic [31:0] w;
      b = 8'(i * 7 + 1);
      w = 32'(i);
      return {16{b}} ^ {4{w}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [127:0] d, input bit acc,
                       input logic [31:0] ea);
      exp_t e;
      bus.recon_addr  = a;
      bus.recon_data  = d;
      bus.recon_wr_en = 1'b1;
      if (acc) begin
         e.addr = ea;
         e.data = d;
         exp_q.push_back(e);
      end
      tick();
      bus.recon_wr_en = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int c;
      bus.recon_wr_en  = 1'b0;
      bus.recon_addr   = '0;
      bus.recon_data   = '0;
      bus.mem_wr_ready = 1'b0;
      tile_done = 1'b0;
      clear     = 1'b0;
      base_addr = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", 128'(fifo_level), 128'd0);
      chk("rst_valid", 128'(bus.mem_wr_valid), 128'd0);
      chk("rst_overflow", 128'(overflow), 128'd0);
      chk("rst_beat_count", 128'(beat_count), 128'd0);
      chk("rst_wb_done", 128'(wb_done), 128'd0);
      chk("rst_addr", 128'(bus.mem_wr_addr), 128'd0);
      chk("rst_data", bus.mem_wr_data, 128'd0);
      rst_n = 1'b1;
      tick();

      // Single beat, fall-through latency
      base_addr = 32'h0000_1000;
      push(32'd3, 128'h0F0E0D0C0B0A09080706050403020100, 1'b1, 32'h0000_1030);
      chk("ft_valid", 128'(bus.mem_wr_valid), 128'd1);
      chk("ft_level", 128'(fifo_level), 128'd1);
      chk("ft_addr", 128'(bus.mem_wr_addr), 128'h1030);
      bus.mem_wr_ready = 1'b1;
      wait_empty(20);
      chk("single_beat_count", 128'(beat_count), 128'd1);
      chk("single_overflow", 128'(overflow), 128'd0);

      // Backpressure and overflow
      do_clear();
      bus.mem_wr_ready = 1'b0;
      base_addr = '0;
      w0 = n_writes;
      for (int i = 0; i < 10; i++) push(32'(i), pat(i), i < 8, 32'(i) << 4);
      chk("ovf_level", 128'(fifo_level), 128'd8);
      chk("ovf_flag", 128'(overflow), 128'd1);
      bus.mem_wr_ready = 1'b1;
      wait_empty(40);
      tick();
      chk("ovf_writes", 128'(n_writes - w0), 128'd8);
      chk("ovf_beat_count", 128'(beat_count), 128'd8);
      chk("ovf_sticky", 128'(overflow), 128'd1);
      chk("ovf_level_empty", 128'(fifo_level), 128'd0);

      // Full FIFO with simultaneous pop: nothing dropped
      do_clear();
      bus.mem_wr_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(32'(100 + i), pat(100 + i), 1'b1, 32'(100 + i) << 4);
      chk("full_level", 128'(fifo_level), 128'd8);
      bus.mem_wr_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push(32'(200 + i), pat(200 + i), 1'b1, 32'(200 + i) << 4);
         chk("fwp_level", 128'(fifo_level), 128'd8);
         chk("fwp_overflow", 128'(overflow), 128'd0);
      end
      wait_empty(40);
      chk("fwp_beat_count", 128'(beat_count), 128'd28);

      // Completion: 64 beats, ready toggling, tile_done with the last beat
      do_clear();
      base_addr = 32'h2000_0000;
      w0 = wb_pulses;
      for (int i = 0; i < 64; i++) begin
         exp_t e;
         bus.recon_addr   = 32'(i * 4);
         bus.recon_data   = pat(i + 300);
         bus.recon_wr_en  = 1'b1;
         bus.mem_wr_ready = 1'b1;
         tile_done        = (i == 63);
         e.addr = 32'h2000_0000 + 32'(i * 64);
         e.data = pat(i + 300);
         exp_q.push_back(e);
         tick();
         bus.recon_wr_en  = 1'b0;
         tile_done        = 1'b0;
         bus.mem_wr_ready = 1'b0;
         tick();
      end
      for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
         bus.mem_wr_ready = 1'b1;
         tick();
         bus.mem_wr_ready = 1'b0;
         tick();
      end
      chk("cmp_drained", 128'(exp_q.size()), 128'd0);
      repeat (4) tick();
      chk("cmp_pulses", 128'(wb_pulses - w0), 128'd1);
      chk("cmp_pulse_edge", 128'(last_wb_edge), 128'(last_hs_edge + 1));
      chk("cmp_beat_count", 128'(beat_count), 128'd64);

      // tile_done held five cycles with FIFO empty: single pulse, fixed latency
      w0 = wb_pulses;
      tile_done = 1'b1;
      c = cyc;
      repeat (5) tick();
      tile_done = 1'b0;
      repeat (5) tick();
      chk("hold_pulses", 128'(wb_pulses - w0), 128'd1);
      chk("hold_pulse_edge", 128'(last_wb_edge), 128'(c + 2));

      // Clear after overflow; queued data still written
      bus.mem_wr_ready = 1'b0;
      base_addr = 32'h0000_3000;
      for (int i = 0; i < 10; i++)
         push(32'(i), pat(i + 500), i < 8, 32'h0000_3000 + (32'(i) << 4));
      chk("clr_ovf_before", 128'(overflow), 128'd1);
      do_clear();
      chk("clr_overflow", 128'(overflow), 128'd0);
      chk("clr_beat_count", 128'(beat_count), 128'd0);
      chk("clr_level", 128'(fifo_level), 128'd8);
      bus.mem_wr_ready = 1'b1;
      wait_empty(40);
      chk("clr_beat_count_after", 128'(beat_count), 128'd8);
      chk("clr_overflow_after", 128'(overflow), 128'd0);

      // Reset mid-drain discards queued beats
      bus.mem_wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(32'(i), pat(i + 700), 1'b1, 32'h0000_3000 + (32'(i) << 4));
      chk("rmd_level_before", 128'(fifo_level), 128'd4);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("rmd_valid", 128'(bus.mem_wr_valid), 128'd0);
      chk("rmd_level", 128'(fifo_level), 128'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.mem_wr_ready = 1'b1;
      w0 = n_writes;
      repeat (6) tick();
      chk("rmd_no_writes", 128'(n_writes - w0), 128'd0);
      chk("rmd_valid_after", 128'(bus.mem_wr_valid), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
